// File: rtl/adc_scan_sequencer.sv
// Round-robin scan scheduler for an 8-channel SPI ADC with one-frame result pipeline compensation.
// Optional build macro ADC_SEQ_IIR_EN adds a per-channel first-order IIR filter on the result bank.
module adc_scan_sequencer #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned SCAN_DIV = 2500,
  parameter bit          UNIPOLAR = 1'b1
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        frame_start,
  output logic [11:0] frame_cfg,
  input  logic        frame_busy,
  input  logic        frame_done,
  input  logic [11:0] frame_data,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        scan_done,
  output logic        overrun,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data
);

  localparam int unsigned DW = 12;
  localparam int unsigned CHN = 8;
  localparam int unsigned TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TMR_MAX = TW'(SCAN_DIV - 1);
  localparam logic [7:0] CH_LIM = 8'((32'd1 << NUM_CH) - 32'd1);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, START, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q;
  logic            tick;
  logic [7:0]      eff_mask;
  logic [2:0]      cur_ch_q, cur_ch_d;
  logic [2:0]      prev_ch_q, prev_ch_d;
  logic            prev_valid_q, prev_valid_d;
  logic            start_d, ovr_d, smp_valid_d, scan_done_d;
  logic [DW-1:0]   cfg_d, smp_data_d, new_val;
  logic [2:0]      smp_ch_d;
  logic [DW-1:0]   bank_q [CHN];

  function automatic logic [DW-1:0] cfg_word(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], UNIPOLAR, 1'b0, 6'b0};
  endfunction

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest_ch = 3'(i);
  endfunction

  function automatic logic [2:0] highest_ch(input logic [7:0] m);
    highest_ch = 3'd0;
    for (int i = 0; i < 8; i++) if (m[i]) highest_ch = 3'(i);
  endfunction

  // Smallest wrapping offset wins; a lone channel keeps itself.
  function automatic logic [2:0] next_ch(input logic [2:0] c, input logic [7:0] m);
    next_ch = c;
    for (int i = 7; i >= 1; i--) if (m[3'(c + 3'(i))]) next_ch = 3'(c + 3'(i));
  endfunction

  assign eff_mask = ch_mask & CH_LIM;
  assign tick     = enable && (tmr_q == '0);
  assign rd_data  = bank_q[rd_ch];

`ifdef ADC_SEQ_IIR_EN
  logic [CHN-1:0]    seeded_q;
  logic [DW-1:0]     old_val;
  logic signed [12:0] diff, diff_sh;

  // y + ((x - y) >>> 2); an unseeded channel takes x directly.
  assign old_val = bank_q[prev_ch_q];
  assign diff    = $signed({1'b0, frame_data}) - $signed({1'b0, old_val});
  assign diff_sh = diff >>> 2;
  assign new_val = seeded_q[prev_ch_q] ? DW'(old_val + DW'(diff_sh)) : frame_data;
`else
  assign new_val = frame_data;
`endif

  // Interval timer, parked at reload value while disabled.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n)                  tmr_q <= TMR_MAX;
    else if (!enable || tmr_q == '0) tmr_q <= TMR_MAX;
    else                           tmr_q <= tmr_q - TW'(1);
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_ch_q     <= '0;
      prev_ch_q    <= '0;
      prev_valid_q <= 1'b0;
      frame_start  <= 1'b0;
      frame_cfg    <= '0;
      overrun      <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      scan_done    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      prev_ch_q    <= prev_ch_d;
      prev_valid_q <= prev_valid_d;
      frame_start  <= start_d;
      frame_cfg    <= cfg_d;
      overrun      <= ovr_d;
      sample_valid <= smp_valid_d;
      sample_ch    <= smp_ch_d;
      sample_data  <= smp_data_d;
      scan_done    <= scan_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    prev_ch_d    = prev_ch_q;
    prev_valid_d = prev_valid_q;
    start_d      = 1'b0;
    cfg_d        = frame_cfg;
    ovr_d        = 1'b0;
    smp_valid_d  = 1'b0;
    smp_ch_d     = sample_ch;
    smp_data_d   = sample_data;
    scan_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && (eff_mask != '0)) begin
          state_d  = WAIT_TICK;
          cur_ch_d = lowest_ch(eff_mask);
        end
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d      = IDLE;
          prev_valid_d = 1'b0;
        end else if (tick) begin
          if (frame_busy) begin
            ovr_d = 1'b1;
          end else begin
            state_d = START;
            start_d = 1'b1;
            cfg_d   = cfg_word(cur_ch_q);
          end
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tick) ovr_d = 1'b1;
        // Data returned now belongs to the channel configured in the previous frame.
        if (frame_done) begin
          if (prev_valid_q) begin
            smp_valid_d = 1'b1;
            smp_ch_d    = prev_ch_q;
            smp_data_d  = new_val;
            scan_done_d = (prev_ch_q == highest_ch(eff_mask));
          end
          prev_ch_d    = cur_ch_q;
          prev_valid_d = 1'b1;
          cur_ch_d     = next_ch(cur_ch_q, eff_mask);
          if (enable && (eff_mask != '0)) begin
            state_d = WAIT_TICK;
          end else begin
            state_d      = IDLE;
            prev_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank write follows the registered sample by one cycle.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(CHN); i++) bank_q[i] <= '0;
`ifdef ADC_SEQ_IIR_EN
      seeded_q <= '0;
`endif
    end else if (sample_valid) begin
      bank_q[sample_ch] <= sample_data;
`ifdef ADC_SEQ_IIR_EN
      seeded_q[sample_ch] <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer: engine BFM plus transaction-level scan model.
// Honors ADC_SEQ_IIR_EN for the filtered-bank expectations.
module tb_adc_scan_sequencer;

  localparam int NUM_CH   = 8;
  localparam int SCAN_DIV = 4;
  localparam bit UNIPOLAR = 1'b1;
  localparam int HOLD_LAT = 5;
  localparam logic [7:0] LIM = 8'((32'd1 << NUM_CH) - 32'd1);

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  ch_mask;
  logic        frame_start;
  logic [11:0] frame_cfg;
  logic        frame_busy = 1'b0;
  logic        frame_done = 1'b0;
  logic [11:0] frame_data = 12'h000;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic        scan_done;
  logic        overrun;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;

  adc_scan_sequencer #(.NUM_CH(NUM_CH), .SCAN_DIV(SCAN_DIV), .UNIPOLAR(UNIPOLAR)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .frame_start(frame_start), .frame_cfg(frame_cfg), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_data(frame_data), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .scan_done(scan_done),
    .overrun(overrun), .rd_ch(rd_ch), .rd_data(rd_data)
  );

  always #5 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules expressed directly from the channel/config definitions.
  function automatic int cfg_of(input int c);
    return 'h800 + ((c % 2) << 10) + (((c / 4) % 2) << 9) + (((c / 2) % 2) << 8) + (int'(UNIPOLAR) << 7);
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int highest(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int pick_next(input int cur, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  typedef struct { int ch; int val; bit sd; } exp_t;
  exp_t exp_q[$];
  int   dq[$];

  int  m_bank[8];
  bit  m_seeded[8];
  int  m_cur, m_prev;
  bit  m_prev_valid, fresh;
  bit  eng_active, mode_prev, hold_once, stray_req;
  int  eng_cnt, tail_cnt, cur_tail, tail_once;
  int  ovr_cnt = 0, starts = 0, samples_seen = 0;

  // Frame engine BFM and scan model, all on the falling edge.
  always @(negedge clk_50) begin
    if (!reset_n) begin
      frame_done = 1'b0; frame_busy = 1'b0;
      eng_active = 1'b0; eng_cnt = 0; tail_cnt = 0; cur_tail = 0;
      exp_q.delete();
      m_prev_valid = 1'b0; fresh = 1'b1; m_cur = 0; m_prev = 0;
      for (int i = 0; i < 8; i++) begin m_bank[i] = 0; m_seeded[i] = 1'b0; end
    end else begin
      frame_done = 1'b0;
      if (overrun) ovr_cnt++;
      if (sample_valid) begin
        samples_seen++;
        if (exp_q.size() == 0) begin
          check_eq("sample_unexpected", sample_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("sample_ch", sample_ch, e.ch);
          check_eq("sample_data", sample_data, e.val);
          check_eq("scan_done", scan_done, e.sd);
        end
      end else if (scan_done) begin
        check_eq("scan_done_alone", scan_done, 1'b0);
      end

      if (frame_start) begin
        starts++;
        check_eq("start_while_busy", eng_active, 1'b0);
        if (fresh) begin m_cur = lowest(ch_mask & LIM); fresh = 1'b0; end
        check_eq("frame_cfg", frame_cfg, cfg_of(m_cur));
        eng_active = 1'b1; frame_busy = 1'b1;
        eng_cnt = hold_once ? HOLD_LAT : int'($urandom_range(1, 0));
        hold_once = 1'b0; cur_tail = tail_once; tail_once = 0;
      end else if (eng_active) begin
        if (eng_cnt > 0) begin
          eng_cnt--;
        end else begin
          int d, v;
          logic [7:0] mask_e;
          check_eq("cfg_stable", frame_cfg, cfg_of(m_cur));
          if (dq.size() != 0) d = dq.pop_front();
          else if (mode_prev) d = 'h100 + m_prev;
          else d = int'($urandom_range(4095, 0));
          frame_data = 12'(d); frame_done = 1'b1; eng_active = 1'b0;
          tail_cnt = cur_tail;
          if (tail_cnt == 0) frame_busy = 1'b0;
          mask_e = ch_mask & LIM;
          if (m_prev_valid) begin
            v = d;
`ifdef ADC_SEQ_IIR_EN
            if (m_seeded[m_prev]) v = (m_bank[m_prev] + ((d - m_bank[m_prev]) >>> 2)) & 'hFFF;
            m_seeded[m_prev] = 1'b1;
`endif
            m_bank[m_prev] = v;
            exp_q.push_back('{m_prev, v, (m_prev == highest(mask_e))});
          end
          m_prev = m_cur; m_prev_valid = 1'b1;
          m_cur = pick_next(m_cur, mask_e);
          if (!(enable && mask_e != 8'h00)) begin m_prev_valid = 1'b0; fresh = 1'b1; end
        end
      end else if (tail_cnt > 0) begin
        tail_cnt--;
        if (tail_cnt == 0) frame_busy = 1'b0;
      end else if (stray_req) begin
        stray_req = 1'b0; frame_data = 12'hFFF; frame_done = 1'b1;
      end
    end
  end

  task automatic wait_samples(input int n);
    int target = samples_seen + n;
    int k = 0;
    while (samples_seen < target && k < 400) begin @(posedge clk_50); #1; k++; end
    if (samples_seen < target) check_eq("timeout_samples", samples_seen, target);
  endtask

  task automatic check_bank(input string tag);
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c); #1;
      check_eq($sformatf("%s_bank%0d", tag, c), rd_data, m_bank[c]);
    end
  endtask

  // Drop enable while a frame is in flight, let it drain, then audit.
  task automatic stop_scan(input string tag);
    int k = 0;
    do begin @(posedge clk_50); k++; end while (!eng_active && k < 200);
    if (!eng_active) check_eq({tag, "_timeout_active"}, eng_active, 1'b1);
    #1 enable = 1'b0;
    k = 0;
    while (eng_active && k < 200) begin @(posedge clk_50); k++; end
    repeat (4) @(posedge clk_50);
    #1;
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_bank(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_frame_start"}, frame_start, 0);
    check_eq({tag, "_frame_cfg"}, frame_cfg, 0);
    check_eq({tag, "_sample_valid"}, sample_valid, 0);
    check_eq({tag, "_sample_ch"}, sample_ch, 0);
    check_eq({tag, "_sample_data"}, sample_data, 0);
    check_eq({tag, "_scan_done"}, scan_done, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c); #1;
      check_eq($sformatf("%s_rd%0d", tag, c), rd_data, 0);
    end
  endtask

  initial begin
    int ovr0, smp0, st0;
    reset_n = 1'b0; enable = 1'b0; ch_mask = 8'h00; rd_ch = 3'd0;
    mode_prev = 1'b0; hold_once = 1'b0; stray_req = 1'b0; tail_once = 0;
    repeat (3) @(posedge clk_50);
    #1 check_outputs_zero("reset");
    @(posedge clk_50); #1 reset_n = 1'b1;

    // Single channel: first frame discarded, then 0x400, 0x800.
    ovr0 = ovr_cnt;
    dq = {12'h123, 12'h400, 12'h800};
    ch_mask = 8'h01; enable = 1'b1;
    wait_samples(1);
    rd_ch = 3'd0; #1 check_eq("ch0_first", rd_data, 12'h400);
    wait_samples(1);
    rd_ch = 3'd0; #1;
`ifdef ADC_SEQ_IIR_EN
    check_eq("ch0_second", rd_data, 12'h500);
`else
    check_eq("ch0_second", rd_data, 12'h800);
`endif
    wait_samples(3);
    stop_scan("single");

    // Mask A4 with data tagged by the previously configured channel.
    mode_prev = 1'b1; ch_mask = 8'hA4;
    @(posedge clk_50); #1 enable = 1'b1;
    wait_samples(9);
    stop_scan("a4");
    mode_prev = 1'b0;

    for (int it = 0; it < 6; it++) begin
      ch_mask = 8'($urandom_range(255, 1)) & LIM;
      if (ch_mask == 8'h00) ch_mask = 8'h01;
      @(posedge clk_50); #1 enable = 1'b1;
      wait_samples(int'($urandom_range(8, 2)));
      stop_scan($sformatf("rand%0d", it));
    end
    check_eq("overrun_none", ovr_cnt - ovr0, 0);

    // Engine stalls one frame across a tick.
    ch_mask = 8'($urandom_range(255, 1)) & LIM;
    if (ch_mask == 8'h00) ch_mask = 8'h80;
    @(posedge clk_50); #1 enable = 1'b1;
    wait_samples(1);
    ovr0 = ovr_cnt; st0 = starts; hold_once = 1'b1;
    repeat (30) @(posedge clk_50);
    #1 check_eq("overrun_hold", ovr_cnt - ovr0, 1);
    check_eq("hold_restarted", (starts - st0) > 0, 1);
    // Engine stays busy past its done across a tick.
    ovr0 = ovr_cnt; tail_once = 3;
    repeat (30) @(posedge clk_50);
    #1 check_eq("overrun_busy", ovr_cnt - ovr0, 1);
    stop_scan("ovr");

    // Re-enable after an in-flight drop: next frame's data is thrown away.
    ch_mask = 8'h3C;
    @(posedge clk_50); #1 enable = 1'b1;
    wait_samples(2);
    stop_scan("drop");
    dq = {12'hABC};
    @(posedge clk_50); #1 enable = 1'b1;
    wait_samples(3);
    stop_scan("reenable");

    // Reset in the middle of a frame, then a stray done while idle.
    ch_mask = 8'($urandom_range(255, 1)) & LIM;
    if (ch_mask == 8'h00) ch_mask = 8'h02;
    @(posedge clk_50); #1 enable = 1'b1;
    wait_samples(2);
    begin
      int k = 0;
      do begin @(posedge clk_50); k++; end while (!eng_active && k < 200);
    end
    #1 reset_n = 1'b0; enable = 1'b0;
    #1 check_outputs_zero("midrst");
    @(posedge clk_50); #1 reset_n = 1'b1;
    smp0 = samples_seen; st0 = starts; stray_req = 1'b1;
    repeat (6) @(posedge clk_50);
    #1 check_eq("stray_sample", samples_seen - smp0, 0);
    check_eq("stray_start", starts - st0, 0);
    check_bank("post_rst");

    ch_mask = 8'h81;
    @(posedge clk_50); #1 enable = 1'b1;
    wait_samples(4);
    stop_scan("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
